io_bus_arbiter: RTL

- Shares the single IO-mapped bus port (address/data-in/control into the IO block, data-out back) between two requesters: A (CPU core) and B (DMA/boot-loader engine).
- Issues at most one access per cycle and tracks in-flight reads through the IO block's fixed read latency.
- Returns each read's data to the requester that issued it.
- Sits between the requesters and the IO block; the IO block is unchanged.

---
 rtl/io_bus_pkg.sv | 35 +++
 rtl/io_read_tracker.sv | 46 ++++
 rtl/io_bus_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus arbiter slice.
//   req_id_e  : requester identity carried through the read tracker
//   io_req_t  : one requester's access fields {addr, wdata, ctrl}
//   CTRL_*    : bit positions inside the 2-bit control field
//   DEV_*     : device-select codes found in address bits [25:23]
package io_bus_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int CTRL_WRITE   = 1;
  localparam int CTRL_BYTE    = 0;

  localparam int IO_SPACE_BIT = 31;
  localparam int DEV_SEL_MSB  = 25;
  localparam int DEV_SEL_LSB  = 23;

  localparam logic [2:0] DEV_LED = 3'd0;
  localparam logic [2:0] DEV_VGA = 3'd1;
  localparam logic [2:0] DEV_SD  = 3'd2;
  localparam logic [2:0] DEV_PS2 = 3'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ctrl;
  } io_req_t;

  function automatic logic [2:0] dev_sel(input logic [31:0] addr);
    return addr[DEV_SEL_MSB:DEV_SEL_LSB];
  endfunction

endpackage

// File: rtl/io_read_tracker.sv
// In-flight read tracker: a DEPTH-deep {valid, id} shift register that
// advances every cycle. An entry pushed in cycle T is at the head in
// cycle T+DEPTH.
//   main_clk  : clock
//   reset     : synchronous, active-high; drops every in-flight entry
//   push_vld  : a read is issued this cycle (else a bubble is shifted in)
//   push_id   : requester that issued it
//   head_vld  : head entry is a read whose data is on the bus now
//   head_id   : requester owning the head entry
//   busy      : any entry valid
module io_read_tracker
  import io_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    main_clk,
  input  logic    reset,
  input  logic    push_vld,
  input  req_id_e push_id,
  output logic    head_vld,
  output req_id_e head_id,
  output logic    busy
);

  logic    [DEPTH-1:0] vld_pipe;
  req_id_e [DEPTH-1:0] id_pipe;

  always_ff @(posedge main_clk) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= {DEPTH{REQ_A}};
    end else begin
      vld_pipe[0] <= push_vld;
      id_pipe[0]  <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign head_vld = vld_pipe[DEPTH-1];
  assign head_id  = id_pipe[DEPTH-1];
  assign busy     = |vld_pipe;

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-requester arbiter in front of the IO block. One access is issued per
// cycle (grant is combinational in the request cycle); reads are tracked
// through the IO block's fixed latency and their data is routed back to
// the issuer.
//   main_clk, reset        : clock, synchronous active-high reset
//   a_* / b_*              : requester A (CPU) / B (DMA) request + response
//   io_address/_data_in/_control : to IO block, muxed from the winner
//   io_data_out            : read data from IO block
//   busy                   : at least one read in flight
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int READ_LATENCY   = 2,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        main_clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [1:0]  a_ctrl,
  output logic        a_grant,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [1:0]  b_ctrl,
  output logic        b_grant,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [31:0] io_address,
  output logic [15:0] io_data_in,
  output logic [1:0]  io_control,
  input  logic [15:0] io_data_out,
  output logic        busy
);

  req_id_e rr_ptr;
  logic    a_win, b_win;
  io_req_t sel;
  logic    head_vld;
  req_id_e head_id;

  // A wins when alone, under fixed priority, or when it holds the pointer.
  assign a_win   = a_req && (!b_req || (FIXED_PRIORITY != 0) || (rr_ptr == REQ_A));
  assign b_win   = b_req && !a_win;
  // Grants are held low during reset so nothing reaches the IO block.
  assign a_grant = a_win && !reset;
  assign b_grant = b_win && !reset;

  // Pointer moves to the loser, and only under contention.
  always_ff @(posedge main_clk) begin
    if (reset)              rr_ptr <= REQ_A;
    else if (a_req && b_req) rr_ptr <= a_win ? REQ_B : REQ_A;
  end

  // Idle bus drives all zeros, so no write strobe without a grant.
  always_comb begin
    sel = '0;
    if (a_grant)      sel = '{addr: a_addr, wdata: a_wdata, ctrl: a_ctrl};
    else if (b_grant) sel = '{addr: b_addr, wdata: b_wdata, ctrl: b_ctrl};
  end

  assign io_address = sel.addr;
  assign io_data_in = sel.wdata;
  assign io_control = sel.ctrl;

  io_read_tracker #(.DEPTH(READ_LATENCY)) u_trk (
    .main_clk (main_clk),
    .reset    (reset),
    .push_vld ((a_grant || b_grant) && !sel.ctrl[CTRL_WRITE]),
    .push_id  (b_grant ? REQ_B : REQ_A),
    .head_vld (head_vld),
    .head_id  (head_id),
    .busy     (busy)
  );

  // Response path, one lane per requester: pass-through on the rvalid
  // cycle, last captured value otherwise.
  logic [1:0]       rvalid_vec;
  logic [1:0][15:0] rdata_q;
  logic [1:0][15:0] rdata_vec;

  for (genvar r = 0; r < 2; r++) begin : g_rsp
    assign rvalid_vec[r] = head_vld && (head_id == req_id_e'(r));
    assign rdata_vec[r]  = rvalid_vec[r] ? io_data_out : rdata_q[r];
    always_ff @(posedge main_clk) begin
      if (reset)              rdata_q[r] <= '0;
      else if (rvalid_vec[r]) rdata_q[r] <= io_data_out;
    end
  end

  assign a_rvalid = rvalid_vec[REQ_A];
  assign b_rvalid = rvalid_vec[REQ_B];
  assign a_rdata  = rdata_vec[REQ_A];
  assign b_rdata  = rdata_vec[REQ_B];

endmodule
